// File: rtl/upload_arbiter.sv
// upload_arbiter: round-robin, per-burst arbiter that shares one registered
// upload path into the command processor among several peripheral byte sources.
module upload_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int IDX_W       = 2,
    parameter int MAX_BURST   = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SOURCES-1:0]   src_req_in,
    input  logic [NUM_SOURCES-1:0]   src_valid_in,
    input  logic [8*NUM_SOURCES-1:0] src_data_in,
    input  logic [8*NUM_SOURCES-1:0] src_source_in,
    output logic [NUM_SOURCES-1:0]   src_ready_out,
    output logic                     upload_req_out,
    output logic                     upload_valid_out,
    output logic [7:0]               upload_data_out,
    output logic [7:0]               upload_source_out,
    input  logic                     upload_ready_in,
    output logic [IDX_W-1:0]         grant_idx_out,
    output logic                     busy_out
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    // With MAX_BURST == 0 this wraps to all-ones, but w_lastByte is gated off.
    localparam logic [15:0]      LAST_CNT = 16'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SOURCES - 1);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_grantIdx;
    logic [IDX_W-1:0]       r_rrPtr;
    logic [15:0]            r_burstCnt;
    logic                   r_uploadReq;
    logic                   r_uploadValid;
    logic [7:0]             r_data;
    logic [7:0]             r_source;
    logic                   r_busy;

    logic [IDX_W-1:0]       w_pickIdx;
    logic [IDX_W-1:0]       w_nextPtr;
    logic                   w_found;
    logic                   w_anyReq;
    logic                   w_holderReq;
    logic                   w_xfer;
    logic                   w_lastByte;
    logic                   w_release;
    logic [NUM_SOURCES-1:0] w_ready;

    // First requester at or above the round-robin pointer, wrapping around.
    always_comb begin
        w_pickIdx = r_rrPtr;
        w_found   = 1'b0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (!w_found && src_req_in[(int'(r_rrPtr) + k) % NUM_SOURCES]) begin
                w_pickIdx = IDX_W'((int'(r_rrPtr) + k) % NUM_SOURCES);
                w_found   = 1'b1;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == GRANT) begin
            w_ready[r_grantIdx] = upload_ready_in & w_holderReq;
        end
    end

    assign w_anyReq    = |src_req_in;
    assign w_holderReq = src_req_in[r_grantIdx];
    assign w_xfer      = (r_state == GRANT) && src_valid_in[r_grantIdx] && w_ready[r_grantIdx];
    assign w_lastByte  = (MAX_BURST != 0) && w_xfer && (r_burstCnt == LAST_CNT);
    assign w_release   = (r_state == GRANT) && (!w_holderReq || w_lastByte);
    assign w_nextPtr   = (r_grantIdx == LAST_IDX) ? '0 : r_grantIdx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grantIdx    <= '0;
            r_rrPtr       <= '0;
            r_burstCnt    <= '0;
            r_uploadReq   <= 1'b0;
            r_uploadValid <= 1'b0;
            r_data        <= '0;
            r_source      <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_uploadValid <= w_xfer;
            if (w_xfer) begin
                r_data     <= src_data_in[8*r_grantIdx +: 8];
                r_source   <= src_source_in[8*r_grantIdx +: 8];
                r_burstCnt <= r_burstCnt + 16'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_state     <= GRANT;
                        r_grantIdx  <= w_pickIdx;
                        r_burstCnt  <= '0;
                        r_uploadReq <= 1'b1;
                        r_busy      <= 1'b1;
                    end else begin
                        r_uploadReq <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                GRANT: begin
                    r_busy <= 1'b1;
                    if (w_release) begin
                        // The final byte of a forced release keeps the request up one more cycle.
                        r_state     <= GAP;
                        r_rrPtr     <= w_nextPtr;
                        r_uploadReq <= w_xfer;
                    end else begin
                        r_uploadReq <= 1'b1;
                    end
                end
                GAP: begin
                    r_state     <= IDLE;
                    r_uploadReq <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_uploadReq <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign src_ready_out     = w_ready;
    assign upload_req_out    = r_uploadReq;
    assign upload_valid_out  = r_uploadValid;
    assign upload_data_out   = r_data;
    assign upload_source_out = r_source;
    assign grant_idx_out     = r_grantIdx;
    assign busy_out          = r_busy;

endmodule

// File: tb/tb_upload_arbiter.sv
// tb_upload_arbiter: directed self-checking bench for upload_arbiter with a
// small queue-driven model of each peripheral source.
module tb_upload_arbiter;

    localparam int NS    = 4;
    localparam int IDX_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS-1:0]     src_req_in = '0;
    logic [NS-1:0]     src_valid_in = '0;
    logic [8*NS-1:0]   src_data_in = '0;
    logic [8*NS-1:0]   src_source_in = '0;
    logic [NS-1:0]     src_ready_out;
    logic              upload_req_out;
    logic              upload_valid_out;
    logic [7:0]        upload_data_out;
    logic [7:0]        upload_source_out;
    logic              upload_ready_in = 1'b1;
    logic [IDX_W-1:0]  grant_idx_out;
    logic              busy_out;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0]  srcQ [NS][$];
    logic [NS-1:0] autoReq = '0;
    logic [NS-1:0] reqManual = '0;
    logic [NS-1:0] reqVal = '0;
    logic [15:0] outLog [$];
    logic [15:0] expLog [$];
    logic [7:0]  grantLog [$];
    logic [7:0]  expGrant [$];
    logic        prevReq = 1'b0;

    upload_arbiter #(
        .NUM_SOURCES(NS),
        .IDX_W(IDX_W),
        .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_req_in(src_req_in),
        .src_valid_in(src_valid_in),
        .src_data_in(src_data_in),
        .src_source_in(src_source_in),
        .src_ready_out(src_ready_out),
        .upload_req_out(upload_req_out),
        .upload_valid_out(upload_valid_out),
        .upload_data_out(upload_data_out),
        .upload_source_out(upload_source_out),
        .upload_ready_in(upload_ready_in),
        .grant_idx_out(grant_idx_out),
        .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Each source presents the head of its queue; auto requests drop once the queue drains.
    task automatic applyStimulus();
        for (int s = 0; s < NS; s++) begin
            src_valid_in[s]        = (srcQ[s].size() > 0);
            src_data_in[8*s +: 8]  = (srcQ[s].size() > 0) ? srcQ[s][0] : 8'h00;
            src_source_in[8*s +: 8] = 8'(8'hA0 + s);
            src_req_in[s]          = reqManual[s] ? reqVal[s] : (autoReq[s] && (srcQ[s].size() > 0));
        end
    endtask

    task automatic tick();
        logic [NS-1:0] accepted;
        @(negedge clk);
        accepted = src_ready_out & src_valid_in;
        if (upload_valid_out) outLog.push_back({upload_source_out, upload_data_out});
        if (upload_req_out && !prevReq) grantLog.push_back(8'(grant_idx_out));
        prevReq = upload_req_out;
        @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++) begin
            if (accepted[s] && srcQ[s].size() > 0) void'(srcQ[s].pop_front());
        end
        applyStimulus();
    endtask

    task automatic runCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        for (int s = 0; s < NS; s++) srcQ[s].delete();
        autoReq = '0;
        reqManual = '0;
        reqVal = '0;
        upload_ready_in = 1'b1;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        outLog.delete();
        grantLog.delete();
        prevReq = 1'b0;
    endtask

    task automatic checkLog(input string tag);
        checkOutput({tag, "_len"}, 32'(outLog.size()), 32'(expLog.size()));
        for (int i = 0; i < expLog.size(); i++) begin
            if (i < outLog.size()) checkOutput($sformatf("%s_%0d", tag, i), 32'(outLog[i]), 32'(expLog[i]));
        end
    endtask

    task automatic checkGrants(input string tag);
        checkOutput({tag, "_len"}, 32'(grantLog.size()), 32'(expGrant.size()));
        for (int i = 0; i < expGrant.size(); i++) begin
            if (i < grantLog.size()) checkOutput($sformatf("%s_%0d", tag, i), 32'(grantLog[i]), 32'(expGrant[i]));
        end
    endtask

    initial begin
        #1;
        checkOutput("rst_req", 32'(upload_req_out), 32'd0);
        checkOutput("rst_valid", 32'(upload_valid_out), 32'd0);
        checkOutput("rst_busy", 32'(busy_out), 32'd0);
        checkOutput("rst_data", 32'(upload_data_out), 32'd0);
        checkOutput("rst_source", 32'(upload_source_out), 32'd0);
        checkOutput("rst_grant", 32'(grant_idx_out), 32'd0);
        checkOutput("rst_ready", 32'(src_ready_out), 32'd0);

        // Single source, three bytes.
        applyReset();
        srcQ[0] = {8'h11, 8'h22, 8'h33};
        autoReq[0] = 1'b1;
        applyStimulus();
        #1;
        checkOutput("ss_req_c0", 32'(upload_req_out), 32'd0);
        checkOutput("ss_ready_c0", 32'(src_ready_out), 32'd0);
        tick();
        checkOutput("ss_req_c1", 32'(upload_req_out), 32'd1);
        checkOutput("ss_busy_c1", 32'(busy_out), 32'd1);
        checkOutput("ss_ready_c1", 32'(src_ready_out), 32'b0001);
        tick();
        checkOutput("ss_valid_c2", 32'(upload_valid_out), 32'd1);
        checkOutput("ss_data_c2", 32'(upload_data_out), 32'h11);
        checkOutput("ss_src_c2", 32'(upload_source_out), 32'hA0);
        tick();
        checkOutput("ss_data_c3", 32'(upload_data_out), 32'h22);
        tick();
        checkOutput("ss_data_c4", 32'(upload_data_out), 32'h33);
        checkOutput("ss_req_c4", 32'(upload_req_out), 32'd1);
        tick();
        checkOutput("ss_req_gap", 32'(upload_req_out), 32'd0);
        checkOutput("ss_busy_gap", 32'(busy_out), 32'd1);
        checkOutput("ss_valid_gap", 32'(upload_valid_out), 32'd0);
        tick();
        checkOutput("ss_busy_idle", 32'(busy_out), 32'd0);
        expLog = {16'hA011, 16'hA022, 16'hA033};
        checkLog("ss_log");

        // Round robin among 0, 1, 3 then wrap.
        applyReset();
        srcQ[0] = {8'h01};
        srcQ[1] = {8'h02};
        srcQ[3] = {8'h04};
        autoReq = 4'b1011;
        applyStimulus();
        runCycles(30);
        expLog = {16'hA001, 16'hA102, 16'hA304};
        checkLog("rr_log");
        expGrant = {8'd0, 8'd1, 8'd3};
        checkGrants("rr_grant");
        outLog.delete();
        grantLog.delete();
        srcQ[0] = {8'h05};
        srcQ[1] = {8'h06};
        applyStimulus();
        runCycles(20);
        expLog = {16'hA005, 16'hA106};
        checkLog("rr2_log");
        expGrant = {8'd0, 8'd1};
        checkGrants("rr2_grant");

        // Forced release after four bytes.
        applyReset();
        srcQ[2] = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        autoReq[2] = 1'b1;
        applyStimulus();
        runCycles(2);
        srcQ[1] = {8'h10};
        autoReq[1] = 1'b1;
        applyStimulus();
        runCycles(30);
        expLog = {16'hA220, 16'hA221, 16'hA222, 16'hA223, 16'hA110, 16'hA224, 16'hA225};
        checkLog("fr_log");
        expGrant = {8'd2, 8'd1, 8'd2};
        checkGrants("fr_grant");

        // Backpressure mid-burst.
        applyReset();
        srcQ[3] = {8'h31, 8'h32, 8'h33};
        autoReq[3] = 1'b1;
        applyStimulus();
        tick();
        checkOutput("bp_grant", 32'(grant_idx_out), 32'd3);
        tick();
        upload_ready_in = 1'b0;
        #1;
        checkOutput("bp_ready_s0", 32'(src_ready_out), 32'd0);
        checkOutput("bp_data_s0", 32'(upload_data_out), 32'h31);
        for (int c = 1; c < 3; c++) begin
            tick();
            checkOutput($sformatf("bp_ready_s%0d", c), 32'(src_ready_out), 32'd0);
            checkOutput($sformatf("bp_valid_s%0d", c), 32'(upload_valid_out), 32'd0);
            checkOutput($sformatf("bp_busy_s%0d", c), 32'(busy_out), 32'd1);
        end
        upload_ready_in = 1'b1;
        #1;
        checkOutput("bp_ready_back", 32'(src_ready_out), 32'b1000);
        runCycles(15);
        expLog = {16'hA331, 16'hA332, 16'hA333};
        checkLog("bp_log");

        // Request drop while valid.
        applyReset();
        reqManual[0] = 1'b1;
        reqVal[0] = 1'b1;
        applyStimulus();
        tick();
        checkOutput("rd_req_grant", 32'(upload_req_out), 32'd1);
        reqVal[0] = 1'b0;
        srcQ[0] = {8'hAA};
        applyStimulus();
        #1;
        checkOutput("rd_ready", 32'(src_ready_out), 32'd0);
        tick();
        checkOutput("rd_busy_gap", 32'(busy_out), 32'd1);
        checkOutput("rd_req_gap", 32'(upload_req_out), 32'd0);
        checkOutput("rd_valid_gap", 32'(upload_valid_out), 32'd0);
        tick();
        checkOutput("rd_busy_idle", 32'(busy_out), 32'd0);
        checkOutput("rd_qsize", 32'(srcQ[0].size()), 32'd1);
        expLog.delete();
        checkLog("rd_log");

        // Reset asserted mid-burst.
        applyReset();
        srcQ[0] = {8'h01, 8'h02, 8'h03};
        autoReq[0] = 1'b1;
        applyStimulus();
        runCycles(2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mr_req", 32'(upload_req_out), 32'd0);
        checkOutput("mr_valid", 32'(upload_valid_out), 32'd0);
        checkOutput("mr_busy", 32'(busy_out), 32'd0);
        checkOutput("mr_data", 32'(upload_data_out), 32'd0);
        checkOutput("mr_ready", 32'(src_ready_out), 32'd0);
        srcQ[0].delete();
        autoReq[0] = 1'b0;
        srcQ[1] = {8'h5A};
        autoReq[1] = 1'b1;
        applyStimulus();
        runCycles(2);
        checkOutput("mr_req_held", 32'(upload_req_out), 32'd0);
        rst = 1'b0;
        outLog.delete();
        grantLog.delete();
        prevReq = 1'b0;
        tick();
        checkOutput("mr_grant_idx", 32'(grant_idx_out), 32'd1);
        checkOutput("mr_req_after", 32'(upload_req_out), 32'd1);
        runCycles(10);
        expLog = {16'hA15A};
        checkLog("mr_log");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/upload_arbiter.md
# upload_arbiter

Shares the single upload path into the command processor (upload_req/data/source/valid, ready) among NUM_SOURCES peripheral requesters such as UART RX, SPI RX and ADC capture. Grants are round-robin and per burst; a grant lasts until the holder drops its request or MAX_BURST bytes have been sent. Output is registered. The upload request line is guaranteed low for at least one cycle between grants, so downstream framing can detect a source change.

## Interface
- NUM_SOURCES, 4: number of requesters (2..8).
- IDX_W, 2: grant index width, equal to clog2(NUM_SOURCES).
- MAX_BURST, 256: bytes per grant before a forced release; 0 means unlimited.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- src_req_in  in  NUM_SOURCES  per-source upload request (level).
- src_valid_in  in  NUM_SOURCES  per-source byte valid.
- src_data_in  in  8*NUM_SOURCES  byte of source i at [8i+7:8i].
- src_source_in  in  8*NUM_SOURCES  source-ID tag of source i at [8i+7:8i].
- src_ready_out  out  NUM_SOURCES  byte accepted this cycle when valid and ready are both high (combinational).
- upload_req_out  out  1  registered request to the command processor.
- upload_valid_out  out  1  registered one-cycle byte strobe.
- upload_data_out  out  8  registered byte.
- upload_source_out  out  8  registered source tag of the current byte.
- upload_ready_in  in  1  downstream ready (the command processor's upload_ready_out).
- grant_idx_out  out  IDX_W  index of the current or last grant holder.
- busy_out  out  1  high in GRANT and GAP.

## Operation
- States: IDLE, GRANT, GAP. One-hot or binary encoding is allowed.
- **IDLE**
  - If any src_req_in bit is high, select the first requester searching upward from rr_ptr, modulo NUM_SOURCES.
  - Latch that index into grant_idx_out, clear burst_cnt, and go to GRANT.
  - With no requests, stay in IDLE.
- **GRANT** (g = grant_idx_out)
  - src_ready_out[g] = upload_ready_in and src_req_in[g]. All other src_ready_out bits are 0.
  - Transfer means src_valid_in[g] and src_ready_out[g]. On a transfer, register the data and source of g, pulse upload_valid_out on the next cycle, and increment burst_cnt (16-bit).
  - Exit to GAP when src_req_in[g] is low. A byte presented in that same cycle is not accepted.
  - Also exit to GAP on a transfer with burst_cnt == MAX_BURST-1 (only when MAX_BURST != 0). That last byte is accepted.
  - On exit, rr_ptr = g+1 modulo NUM_SOURCES.
- **GAP**
  - All src_ready_out bits are 0. Go to IDLE after one cycle.
- **upload_req_out**
  - Registered as (next_state == GRANT) or (transfer this cycle).
  - It therefore stays high during the cycle that carries the final byte, and is low for at least the IDLE cycle before the next grant.
- Upload requests not selected by arbitration are held off (ready = 0). No data is dropped or reordered within a source.
- upload_ready_in low in GRANT stalls the transfer. It does not cause a release.

## Timing
- Reset values: upload_req_out, upload_valid_out and busy_out are 0; upload_data_out, upload_source_out and grant_idx_out are 0; src_ready_out is 0; state is IDLE; rr_ptr is 0; burst_cnt is 0.
- A request seen in IDLE at cycle N gives GRANT and upload_req_out=1 at N+1. src_ready_out is high at N+1 at the earliest.
- Acceptance at cycle M gives upload_valid_out, data and source valid at M+1.
- Throughput is 1 byte per cycle while valid and upload_ready_in are held high.
- The minimum idle gap between grants is 2 cycles (GAP, then IDLE). upload_req_out is low in the IDLE cycle.
- Simultaneous requests in IDLE are resolved by rr_ptr. A new request arriving during GRANT waits for release.
- Reset asserted mid-burst forces all outputs to their reset values immediately (asynchronously). Bytes in flight are discarded.

## Test plan
- **Single source:** reset, then src 0 req=1 and sends 0x11, 0x22, 0x33 with upload_ready_in=1, then req=0.
  - upload_req_out rises 1 cycle after req.
  - Three upload_valid_out pulses carry 0x11/0x22/0x33 with the source tag of src 0.
  - upload_req_out drops; busy_out returns to 0 after the GAP and IDLE cycles.
- **Round robin:** sources 0, 1 and 3 request simultaneously, 1 byte each, then drop.
  - Grants are in order 0, 1, 3.
  - Then src 0 and 1 request again; grant goes to src 0 (rr_ptr wrapped).
  - upload_req_out is low for at least 1 cycle between every pair of grants.
- **Forced release:** MAX_BURST=4; src 2 holds req with 6 bytes while src 1 also requests.
  - Src 2 bytes 0..3 are sent, then src 1 is granted, then src 2 resumes with bytes 4..5.
- **Backpressure:** upload_ready_in=0 for 3 cycles mid-burst.
  - src_ready_out stays 0 and there is no upload_valid_out pulse.
  - The burst continues in order once ready returns; no byte is lost or duplicated.
- **Request drop with valid:** src 0 drops req in the same cycle valid=1 with 0xAA.
  - 0xAA is not accepted and src_ready_out[0] is 0.
  - GAP follows.
- **Reset mid-burst:** assert rst during GRANT.
  - All outputs go to 0 while rst is high.
  - After release, src 1 requesting is granted first (rr_ptr = 0 search finds 1).
